operand2_shifter_pipe: RTL and testbench

//  Parametrised, pipelined data-processing operand-2 shifter with full shifter carry-out.

---
 rtl/operand2_shifter_pipe_pkg.sv | 22 ++
 rtl/operand2_shifter_pipe_if.sv | 26 ++
 rtl/operand2_shifter_pipe_shift_core.sv | 78 +++++++
 rtl/operand2_shifter_pipe.sv | 93 +++++++++
 tb/tb_operand2_shifter_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand2_shifter_pipe_pkg.sv
// Shared types for the operand-2 shifter pipeline: shift types, operand-2 modes and the stage-1 payload.
// Optional feature macro used by this slice: OPERAND2_SHIFTER_RRX_EN (immediate ROR #0 becomes RRX).
package shifter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_AMT_W  = 8;
    localparam int AMT_BITS   = $clog2(DEF_DATA_W);

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;

    typedef enum logic [1:0] {MD_IMM, MD_IMM_SHIFT, MD_REG_SHIFT} mode_t;

    // The rotated immediate travels in the rm field, so stage 2 only ever sees one operand.
    typedef struct packed {
        shift_t                sh_type;
        logic [DEF_AMT_W-1:0]  amount;
        mode_t                 mode;
        logic [DEF_DATA_W-1:0] rm;
        logic                  cin;
    } s1_t;

endpackage

// File: rtl/operand2_shifter_pipe_if.sv
// Request/response bundle between register-file read, the operand-2 shifter and the ALU.
// The pipeline takes the slave side; the producer/consumer pair takes the master side.
interface operand2_shifter_pipe_if #(parameter int DATA_W = 32);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rm;
    logic [DATA_W-1:0] rs;
    logic [25:0]       instr;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] src2;
    logic              shifter_cout;

    modport master (
        output in_valid, rm, rs, instr, carry_in, out_ready,
        input  in_ready, out_valid, src2, shifter_cout
    );

    modport slave (
        input  in_valid, rm, rs, instr, carry_in, out_ready,
        output in_ready, out_valid, src2, shifter_cout
    );

endinterface

// File: rtl/operand2_shifter_pipe_shift_core.sv
// Combinational barrel shifter with carry-out, covering the amount-0 and amount>=W special cases.
// OPERAND2_SHIFTER_RRX_EN selects RRX for immediate ROR #0; otherwise that case passes rm through.
module shift_core
    import shifter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  shift_t            sh_type,
    input  logic [AMT_W-1:0]  amount,
    input  logic              amt_is_reg,
    input  logic [DATA_W-1:0] rm,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    localparam int RB = $clog2(DATA_W);

    logic [DATA_W:0]        lsl_w;
    logic [DATA_W:0]        lsr_w;
    logic signed [DATA_W:0] asr_w;
    logic [RB-1:0]          rot_k;
    logic [RB:0]            rot_inv;
    logic [DATA_W-1:0]      ror_w;

    // One extra bit beside rm catches the last bit shifted out, which makes amounts >= W fall out naturally.
    always_comb begin
        lsl_w   = {1'b0, rm} << amount;
        lsr_w   = {rm, 1'b0} >> amount;
        asr_w   = $signed({rm, 1'b0}) >>> amount;
        rot_k   = amount[RB-1:0];
        rot_inv = (RB+1)'(DATA_W) - {1'b0, rot_k};
        ror_w   = (rm >> rot_k) | (rm << rot_inv);
        result  = rm;
        cout    = cin;
        if (amount == '0) begin
            if (!amt_is_reg) begin
                case (sh_type)
                    SH_LSR: begin
                        result = '0;
                        cout   = rm[DATA_W-1];
                    end
                    SH_ASR: begin
                        result = {DATA_W{rm[DATA_W-1]}};
                        cout   = rm[DATA_W-1];
                    end
`ifdef OPERAND2_SHIFTER_RRX_EN
                    SH_ROR: begin
                        result = {cin, rm[DATA_W-1:1]};
                        cout   = rm[0];
                    end
`else
                    SH_ROR: begin
                        result = rm;
                        cout   = cin;
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            case (sh_type)
                SH_LSL: begin
                    result = lsl_w[DATA_W-1:0];
                    cout   = lsl_w[DATA_W];
                end
                SH_LSR: {result, cout} = lsr_w;
                SH_ASR: {result, cout} = asr_w;
                default: begin
                    result = ror_w;
                    cout   = ror_w[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/operand2_shifter_pipe.sv
// Two-stage operand-2 shifter: stage 1 decodes the operand-2 field, stage 2 shifts and holds the result.
// Build option OPERAND2_SHIFTER_RRX_EN (see shift_core) turns immediate ROR #0 into RRX.
module operand2_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    operand2_shifter_pipe_if.slave bus
);

    s1_t               s1_q;
    s1_t               s1_d;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_open;
    logic              accept;
    logic [DATA_W-1:0] src2_q;
    logic              cout_q;
    logic [DATA_W-1:0] core_res;
    logic              core_cout;
    logic              unused_ok;

    assign s2_open     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_open;
    assign accept      = bus.in_valid && bus.in_ready;

    assign bus.out_valid    = s2_valid;
    assign bus.src2         = src2_q;
    assign bus.shifter_cout = cout_q;

    assign unused_ok = ^{bus.instr[24:12], bus.instr[3:0], bus.rs[DATA_W-1:AMT_W]};

    // An immediate is just its zero-extended byte rotated right by twice the rotate field.
    always_comb begin
        s1_d         = '0;
        s1_d.rm      = bus.rm;
        s1_d.cin     = bus.carry_in;
        s1_d.sh_type = shift_t'(bus.instr[6:5]);
        if (bus.instr[25]) begin
            s1_d.mode    = MD_IMM;
            s1_d.sh_type = SH_ROR;
            s1_d.amount  = AMT_W'({bus.instr[11:8], 1'b0});
            s1_d.rm      = DATA_W'(bus.instr[7:0]);
        end else if (bus.instr[4]) begin
            s1_d.mode   = MD_REG_SHIFT;
            s1_d.amount = bus.rs[AMT_W-1:0];
        end else begin
            s1_d.mode   = MD_IMM_SHIFT;
            s1_d.amount = AMT_W'(bus.instr[11:7]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    shift_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_core (
        .sh_type    (s1_q.sh_type),
        .amount     (s1_q.amount),
        .amt_is_reg (s1_q.mode != MD_IMM_SHIFT),
        .rm         (s1_q.rm),
        .cin        (s1_q.cin),
        .result     (core_res),
        .cout       (core_cout)
    );

    // Stage 2 only captures a new result when its current one has been taken, so stalled outputs hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            src2_q   <= '0;
            cout_q   <= 1'b0;
        end else if (s2_open) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                src2_q <= core_res;
                cout_q <= core_cout;
            end
        end
    end

endmodule

// File: tb/tb_operand2_shifter_pipe.sv
// Self-checking bench for operand2_shifter_pipe: directed corner cases, randomized traffic with a
// bit-serial shift model, backpressure and mid-flight reset. Honours OPERAND2_SHIFTER_RRX_EN.
module tb_operand2_shifter_pipe;

    logic clk = 1'b0;
    logic reset;
    int   num_checks = 0;
    int   num_fail = 0;

    logic [32:0] exp_q[$];
    logic [32:0] pend_exp;
    logic        rand_ready = 1'b0;
    logic        ready_force = 1'b1;
    logic        bp_phase = 1'b0;
    logic        bp_seen = 1'b0;

    operand2_shifter_pipe_if #(.DATA_W(32)) bus ();

    operand2_shifter_pipe #(.DATA_W(32), .AMT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic checkOutput(input string tag, input logic [32:0] got, input logic [32:0] want);
        num_checks++;
        if (got !== want) begin
            num_fail++;
            $display("[TB] FAIL %s: observed %h, required %h", tag, got, want);
        end
    endtask

    // Shifts one bit at a time, tracking the last bit to leave as the carry.
    function automatic logic [32:0] ref_model(input logic [31:0] rm_v, input logic [31:0] rs_v,
                                              input logic [25:0] ins, input logic cin);
        logic [31:0] r;
        logic        c;
        int          n;
        logic [1:0]  ty;
        ty = ins[6:5];
        r  = rm_v;
        c  = cin;
        if (ins[25]) begin
            n = 2 * int'(ins[11:8]);
            r = {24'h0, ins[7:0]};
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            if (n != 0) c = r[31];
            return {c, r};
        end
        n = ins[4] ? int'(rs_v[7:0]) : int'(ins[11:7]);
        if (n == 0) begin
            if (!ins[4]) begin
                case (ty)
                    2'd1: begin r = 32'h0; c = rm_v[31]; end
                    2'd2: begin r = {32{rm_v[31]}}; c = rm_v[31]; end
                    2'd3: begin
`ifdef OPERAND2_SHIFTER_RRX_EN
                        r = {cin, rm_v[31:1]};
                        c = rm_v[0];
`endif
                    end
                    default: ;
                endcase
            end
            return {c, r};
        end
        for (int i = 0; i < n; i++) begin
            case (ty)
                2'd0: begin c = r[31]; r = {r[30:0], 1'b0}; end
                2'd1: begin c = r[0]; r = {1'b0, r[31:1]}; end
                2'd2: begin c = r[0]; r = {r[31], r[31:1]}; end
                default: r = {r[0], r[31:1]};
            endcase
        end
        if (ty == 2'd3) c = r[31];
        return {c, r};
    endfunction

    // Sampled mid-cycle: transfers flagged here complete at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bp_phase && bus.in_valid && !bus.in_ready) bp_seen = 1'b1;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(pend_exp);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 33'(bus.out_valid), 33'd0);
                end else if (bus.out_ready) begin
                    checkOutput("result", {bus.shifter_cout, bus.src2}, exp_q.pop_front());
                end else begin
                    checkOutput("stall_hold", {bus.shifter_cout, bus.src2}, exp_q[0]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] rm_v, input logic [31:0] rs_v, input logic [25:0] ins,
                                 input logic cin, input logic use_model, input logic [32:0] exp_v);
        int waited;
        waited = 0;
        pend_exp     = use_model ? ref_model(rm_v, rs_v, ins, cin) : exp_v;
        bus.rm       = rm_v;
        bus.rs       = rs_v;
        bus.instr    = ins;
        bus.carry_in = cin;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 100) begin
                checkOutput("accept_timeout", 33'(bus.in_ready), 33'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", 33'(exp_q.size()), 33'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.rm       = '0;
        bus.rs       = '0;
        bus.instr    = '0;
        bus.carry_in = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 33'(bus.out_valid), 33'd0);
        checkOutput("rst_result", {bus.shifter_cout, bus.src2}, 33'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 33'(bus.in_ready), 33'd1);
        @(posedge clk);
        #1;

        applyStimulus(32'h0, 32'h0, 26'h20004FF, 1'b0, 1'b0, {1'b1, 32'hFF000000});
        checkOutput("lat_early", 33'(bus.out_valid), 33'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_two", 33'(bus.out_valid), 33'd1);
        applyStimulus(32'h0, 32'h0, 26'h2000012, 1'b1, 1'b0, {1'b1, 32'h12});
        applyStimulus(32'h0, 32'h0, 26'h2000012, 1'b0, 1'b0, {1'b0, 32'h12});
        applyStimulus(32'h80000001, 32'h0, 26'h0000020, 1'b0, 1'b0, {1'b1, 32'h0});
        applyStimulus(32'h80000001, 32'h0, 26'h0000040, 1'b0, 1'b0, {1'b1, 32'hFFFFFFFF});
        applyStimulus(32'h0000000F, 32'd32, 26'h0000010, 1'b0, 1'b0, {1'b1, 32'h0});
        applyStimulus(32'h0000000F, 32'd33, 26'h0000010, 1'b1, 1'b0, {1'b0, 32'h0});
        applyStimulus(32'h0000000F, 32'd256, 26'h0000010, 1'b1, 1'b0, {1'b1, 32'hF});
        applyStimulus(32'h0000000F, 32'd256, 26'h0000010, 1'b0, 1'b0, {1'b0, 32'hF});
`ifdef OPERAND2_SHIFTER_RRX_EN
        applyStimulus(32'h00000003, 32'h0, 26'h0000060, 1'b1, 1'b0, {1'b1, 32'h80000001});
`else
        applyStimulus(32'h00000003, 32'h0, 26'h0000060, 1'b1, 1'b0, {1'b1, 32'h3});
`endif
        applyStimulus(32'h80000001, 32'd32, 26'h0000030, 1'b0, 1'b0, {1'b1, 32'h0});
        applyStimulus(32'h80000001, 32'd64, 26'h0000070, 1'b0, 1'b0, {1'b1, 32'h80000001});
        applyStimulus(32'hF0000001, 32'd4, 26'h0000010, 1'b0, 1'b0, {1'b1, 32'h10});
        applyStimulus(32'h80000000, 32'd40, 26'h0000050, 1'b0, 1'b0, {1'b1, 32'hFFFFFFFF});
        applyStimulus(32'h12345678, 32'h0, 26'h0000000, 1'b1, 1'b0, {1'b1, 32'h12345678});
        applyStimulus(32'hF0000001, 32'h0, 26'h0000200, 1'b0, 1'b0, {1'b1, 32'h10});
        waitDrain();

        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] rs_r;
            rs_r = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 70);
            applyStimulus($urandom, rs_r, 26'($urandom), 1'($urandom), 1'b1, 33'd0);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        waitDrain();

        bp_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus($urandom, $urandom_range(0, 40), 26'($urandom), 1'($urandom), 1'b1, 33'd0);
            end
            begin
                for (int c = 1; c <= 8; c++) begin
                    @(posedge clk);
                    #1;
                    ready_force = !(c >= 2 && c <= 4);
                end
            end
        join
        ready_force = 1'b1;
        waitDrain();
        bp_phase = 1'b0;
        checkOutput("bp_in_ready_drop", 33'(bp_seen), 33'd1);

        ready_force = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'hA5A5A5A5, 32'd3, 26'h0000010, 1'b0, 1'b1, 33'd0);
        applyStimulus(32'h5A5A5A5A, 32'd5, 26'h0000030, 1'b1, 1'b1, 33'd0);
        checkOutput("pre_rst_full", 33'({bus.in_ready, bus.out_valid}), 33'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 33'(bus.out_valid), 33'd0);
        checkOutput("midrst_result", {bus.shifter_cout, bus.src2}, 33'd0);
        ready_force = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'h0, 32'h0, 26'h20004FF, 1'b1, 1'b0, {1'b1, 32'hFF000000});
        checkOutput("post_rst_lat_early", 33'(bus.out_valid), 33'd0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_lat_two", 33'(bus.out_valid), 33'd1);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
        $finish;
    end

endmodule
